example_unshift_rx: RTL
=======================

// Module: example_unshift_rx
// PURPOSE
//  Receive-side counterpart of the left-shift producer: accepts BUS_WIDTH words that were
//  shifted left by SHIFT, restores them by logical right shift, and flags words whose low SHIFT
//  bits are nonzero (corrupt). Results are buffered in a DEPTH-entry FIFO.
//  The FIFO drains over a valid/ready interface to the downstream consumer.
// PARAMETERS
//  BUS_WIDTH  32  data width, in and out
//  SHIFT       5  shift amount to undo; 1 <= SHIFT < BUS_WIDTH
//  DEPTH       4  FIFO entries; power of two, >= 2
//  CNT_WIDTH   8  width of saturating error counter
// PORTS
//  clk        in   1          single clock, all state on posedge
//  rst        in   1          reset: asynchronous, active-low
//  in_valid   in   1          upstream word present
//  in_data    in   BUS_WIDTH  shifted word
//  in_ready   out  1          block can accept (= state != FULL)
//  out_valid  out  1          FIFO head valid (= state != EMPTY)
//  out_data   out  BUS_WIDTH  restored word at FIFO head
//  out_err    out  1          head word had nonzero low SHIFT bits
//  out_ready  in   1          downstream consumes head
//  err_clr    in   1          synchronous clear of err_cnt
//  err_cnt    out  CNT_WIDTH  count of corrupt words accepted, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=EMPTY, pointers=0, err_cnt=0; immediately out_valid=0,
//    in_ready=1, out_data=0, out_err=0. A mid-transfer reset discards all buffered words.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at posedge.
//  - Decode on push: data = in_data >> SHIFT (zero-fill MSBs); err = |in_data[SHIFT-1:0].
//    {err,data} is written at the write pointer.
//  - Latency: a word pushed at edge k is visible at out_* from edge k (next cycle) if the FIFO was empty.
//  - out_data/out_err: show-ahead head entry, stable while out_valid=1 and out_ready=0.
//    Held at 0 when EMPTY.
//  - FSM (occupancy count 0..DEPTH tracked alongside):
//      EMPTY : push -> ACTIVE (count=1); pop impossible.
//      ACTIVE: push&!pop -> count+1, FULL if count hits DEPTH; pop&!push -> count-1,
//              EMPTY if count hits 0; push&pop -> count unchanged, both pointers advance.
//      FULL  : in_ready=0, so no push even if pop occurs the same cycle (no bypass);
//              pop -> ACTIVE (count=DEPTH-1).
//  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 without a gap.
//  - in_data is ignored when in_valid=0 or in_ready=0. in_valid while FULL is back-pressure,
//    not an error.
//  - err_cnt: +1 on push with err=1, saturates at 2^CNT_WIDTH-1.
//    err_clr=1 -> 0 next edge; clear wins over a simultaneous increment.
//  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
// TESTING
//  1 Reset: rst=0 mid-burst with 3 words buffered -> out_valid=0, in_ready=1, err_cnt=0 at once;
//    nothing emerges after release.
//  2 Decode: push 0x000001A0 -> out_data=0x0000000D, out_err=0;
//    push 0x000001A3 -> out_data=0x0000000D, out_err=1, err_cnt=1.
//  3 Fill/back-pressure: out_ready=0, push 5 words -> in_ready=0 after the 4th;
//    5th held; drain gives words 1..4 in order, then the 5th.
//  4 Simultaneous: count=2, push+pop every cycle for 10 cycles -> count stays 2;
//    output order matches input; pointers wrap cleanly.
//  5 FULL+pop: FULL, in_valid=1, out_ready=1 for one cycle -> no push that edge; count=3;
//    the word is accepted next cycle.
//  6 Counter: push 300 corrupt words -> err_cnt=255 (saturated);
//    err_clr with corrupt push in same cycle -> err_cnt=0.

Source files
------------

// File: rtl/example_unshift_rx.sv
// example_unshift_rx
//   Receive side of a left-shift link. Each accepted word is restored by a logical right
//   shift of SHIFT bits. A word whose low SHIFT bits are nonzero is flagged as corrupt. The
//   {err, data} pairs are buffered in a DEPTH-entry show-ahead FIFO. The FIFO drains over a
//   valid/ready interface.
//
// Ports
//   clk        in   single clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream word present
//   in_data    in   shifted word
//   in_ready   out  FIFO not full (registered, no path from in_valid)
//   out_valid  out  FIFO not empty (registered, no path from out_ready)
//   out_data   out  restored head word, 0 when empty
//   out_err    out  head word was corrupt, 0 when empty
//   out_ready  in   downstream consumes head
//   err_clr    in   synchronous clear of err_cnt (wins over increment)
//   err_cnt    out  saturating count of corrupt words accepted

module example_unshift_rx #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned SHIFT     = 5,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_err,
    input  logic                 out_ready,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [CntW-1:0]      DepthCnt = CntW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ErrMax   = '1;

    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StFull   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Entry layout: {err, data}
    logic [BUS_WIDTH:0]   mem_q [DEPTH];
    logic [BUS_WIDTH:0]   wr_entry;
    logic [BUS_WIDTH:0]   head;
    logic                 push;
    logic                 pop;
    logic                 wr_err;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_err    = |in_data[SHIFT-1:0];
    assign wr_entry  = {wr_err, in_data >> SHIFT};

    assign head      = mem_q[rptr_q];
    assign out_data  = out_valid ? head[BUS_WIDTH-1:0] : '0;
    assign out_err   = out_valid & head[BUS_WIDTH];
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StActive;
                    count_d = CntW'(1);
                end
            end
            StActive: begin
                if (push && !pop) begin
                    count_d = count_q + 1'b1;
                    if (count_d == DepthCnt) state_d = StFull;
                end else if (pop && !push) begin
                    count_d = count_q - 1'b1;
                    if (count_d == '0) state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so a pop never coincides with a push
                if (pop) begin
                    state_d = StActive;
                    count_d = DepthCnt - 1'b1;
                end
            end
            default: begin
                state_d = StEmpty;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (push && wr_err && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StEmpty;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

endmodule
